// File: rtl/mp_pkg.sv
// mp_pkg: shared defaults and types for the multiprocessor memory arbiter.
package mp_pkg;
    localparam int N_CORES_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef logic [$clog2(N_CORES_DEF)-1:0] core_id_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational N-way picker returning a one-hot winner.
module rr_arbiter
    import mp_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    input  arb_mode_e     mode,
    output logic [N-1:0]  winner
);
    logic [IW-1:0] start;
    logic [IW:0]   idx;
    logic          found;

    // Fixed priority is round-robin with the search always starting at core 0.
    assign start = (mode == ARB_FIXED) ? '0 : ptr;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, start} + (IW+1)'(i);
            if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
            if (!found && eligible[idx[IW-1:0]]) begin
                winner[idx[IW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mp_mem_arbiter.sv
// mp_mem_arbiter: N-core shared single-port memory front end with
// round-robin/fixed arbitration and in-order read return.
module mp_mem_arbiter
    import mp_pkg::*;
#(
    parameter int N_CORES    = N_CORES_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = 1,
    parameter int ARB_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_CORES-1:0]            req,
    input  logic [N_CORES-1:0]            we,
    input  logic [N_CORES*ADDR_WIDTH-1:0] addr,
    input  logic [N_CORES*DATA_WIDTH-1:0] data_in,
    output logic [N_CORES-1:0]            gnt,
    output logic [N_CORES-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);
    localparam int ID_WIDTH = $clog2(N_CORES);
    localparam arb_mode_e MODE = (ARB_MODE != 0) ? ARB_FIXED : ARB_RR;

    function automatic logic [ID_WIDTH-1:0] onehot_id(input logic [N_CORES-1:0] v);
        onehot_id = '0;
        for (int i = 0; i < N_CORES; i++) if (v[i]) onehot_id = ID_WIDTH'(i);
    endfunction

    logic [N_CORES-1:0]  eligible, winner;
    logic [ID_WIDTH-1:0] ptr, win_id, gnt_id;
    logic [RD_LATENCY-1:0] rd_vld;
    logic [ID_WIDTH-1:0]   rd_id [RD_LATENCY];

    // Masking the current grant keeps a held request from winning twice in a row.
    assign eligible = req & ~gnt;
    assign win_id   = onehot_id(winner);
    assign gnt_id   = onehot_id(gnt);

    rr_arbiter #(.N(N_CORES)) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .mode     (MODE),
        .winner   (winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt <= '0;
            ptr <= '0;
        end else begin
            gnt <= winner;
            if (MODE == ARB_RR && |winner)
                ptr <= (win_id == ID_WIDTH'(N_CORES - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // AND-OR mux keeps all command outputs at zero when nothing is granted.
    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_CORES; i++) begin
            mem_we    = mem_we | (gnt[i] & we[i]);
            mem_addr  = mem_addr | ({ADDR_WIDTH{gnt[i]}} & addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            mem_wdata = mem_wdata | ({DATA_WIDTH{gnt[i]}} & data_in[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_id[i] <= '0;
        end else begin
            rd_vld[0] <= mem_en & ~mem_we;
            rd_id[0]  <= gnt_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_id[i]  <= rd_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid   <= '0;
            data_out <= '0;
        end else begin
            rvalid <= rd_vld[RD_LATENCY-1] ? (N_CORES'(1) << rd_id[RD_LATENCY-1]) : '0;
            if (rd_vld[RD_LATENCY-1]) data_out <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mp_mem_arbiter.sv
// tb_mp_mem_arbiter: randomized bench for three arbiter builds (RR lat1, RR lat3,
// fixed lat1) against a cycle-level reference model.
module tb_mp_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0]    req [NI], we [NI], gnt [NI], rvalid [NI];
    logic [N*AW-1:0] addr [NI];
    logic [N*DW-1:0] data_in [NI];
    logic [DW-1:0]   data_out [NI], mem_wdata [NI], mem_rdata [NI];
    logic [AW-1:0]   mem_addr [NI];
    logic            mem_en [NI], mem_we [NI];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 8'h11 : (a == 6) ? 8'h22 : DW'(a * 37 + 11);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 3 : 1;
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] pipe [LAT];

        mp_mem_arbiter #(
            .N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .RD_LATENCY(LAT), .ARB_MODE((g == 2) ? 1 : 0)
        ) dut (
            .clk(clk), .reset_n(reset_n), .req(req[g]), .we(we[g]), .addr(addr[g]),
            .data_in(data_in[g]), .gnt(gnt[g]), .rvalid(rvalid[g]), .data_out(data_out[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        initial for (int a = 0; a < 2**AW; a++) mem[a] <= init_val(a);

        // Write-first single-port memory with LAT cycles of read latency.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
                pipe[0] <= mem_we[g] ? mem_wdata[g] : mem[mem_addr[g]];
            end
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat [NI] = '{1, 3, 1};
    logic [DW-1:0] ref_mem [NI][2**AW];
    int            m_gnt [NI];
    int            m_ptr [NI];
    int            exp_core [NI][8];
    logic [DW-1:0] exp_data [NI][8];
    logic [DW-1:0] last_data [NI];
    logic [N-1:0]  seen [NI];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int g = 0; g < NI; g++) begin
            m_gnt[g] = -1;
            m_ptr[g] = 0;
            last_data[g] = '0;
            for (int s = 0; s < 8; s++) exp_core[g][s] = -1;
        end
    endtask

    // Called mid-cycle: checks this cycle's outputs, then predicts the next grant.
    task automatic check_cycle();
        for (int g = 0; g < NI; g++) begin
            logic [N-1:0]  eg, erv, el;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic          wr;
            int k, s, w, st, idx;
            eg = '0;
            erv = '0;
            k = m_gnt[g];
            if (k >= 0) eg[k] = 1'b1;
            check($sformatf("i%0d gnt", g), 64'(gnt[g]), 64'(eg));
            check($sformatf("i%0d mem_en", g), 64'(mem_en[g]), 64'(k >= 0));
            if (k >= 0) begin
                a  = addr[g][k*AW +: AW];
                d  = data_in[g][k*DW +: DW];
                wr = we[g][k];
                check($sformatf("i%0d mem_we", g), 64'(mem_we[g]), 64'(wr));
                check($sformatf("i%0d mem_addr", g), 64'(mem_addr[g]), 64'(a));
                if (wr) begin
                    check($sformatf("i%0d mem_wdata", g), 64'(mem_wdata[g]), 64'(d));
                    ref_mem[g][a] = d;
                end else begin
                    exp_core[g][(cyc + lat[g] + 1) % 8] = k;
                    exp_data[g][(cyc + lat[g] + 1) % 8] = ref_mem[g][a];
                end
            end
            s = cyc % 8;
            if (exp_core[g][s] >= 0) begin
                erv[exp_core[g][s]] = 1'b1;
                last_data[g] = exp_data[g][s];
                exp_core[g][s] = -1;
            end
            check($sformatf("i%0d rvalid", g), 64'(rvalid[g]), 64'(erv));
            check($sformatf("i%0d data_out", g), 64'(data_out[g]), 64'(last_data[g]));
            seen[g] = gnt[g];
            if (reset_n) begin
                el = req[g] & ~eg;
                st = (g == 2) ? 0 : m_ptr[g];
                w = -1;
                for (int i = 0; i < N; i++) begin
                    idx = (st + i) % N;
                    if (w < 0 && el[idx]) w = idx;
                end
                m_gnt[g] = w;
                if (w >= 0 && g != 2) m_ptr[g] = (w + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic new_req(input int g, input int k);
        req[g][k] = 1'b1;
        we[g][k] = 1'($urandom % 2);
        addr[g][k*AW +: AW] = AW'($urandom_range(0, 15));
        data_in[g][k*DW +: DW] = DW'($urandom);
    endtask

    task automatic drive(input logic [N-1:0] mask, input int p_new, input int p_again);
        for (int g = 0; g < NI; g++)
            for (int k = 0; k < N; k++) begin
                if (req[g][k] && seen[g][k]) begin
                    if (mask[k] && ($urandom % 100) < p_again) new_req(g, k);
                    else req[g][k] = 1'b0;
                end else if (!req[g][k] && mask[k] && ($urandom % 100) < p_new) begin
                    new_req(g, k);
                end
            end
    endtask

    task automatic run(input int n, input logic [N-1:0] mask, input int p_new, input int p_again);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1 drive(mask, p_new, p_again);
        end
    endtask

    task automatic set_all(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int g = 0; g < NI; g++) begin
            req[g][k] = 1'b1;
            we[g][k] = w;
            addr[g][k*AW +: AW] = a;
            data_in[g][k*DW +: DW] = d;
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            req[g] = '0; we[g] = '0; addr[g] = '0; data_in[g] = '0; seen[g] = '0;
            for (int a = 0; a < 2**AW; a++) ref_mem[g][a] = init_val(a);
        end
        reset_model();
        repeat (2) @(posedge clk);
        run(2, '0, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        set_all(2, 1'b1, 11'h010, 8'hA5);
        run(3, '0, 0, 0);
        set_all(2, 1'b0, 11'h010, 8'h00);
        run(6, '0, 0, 0);
        set_all(0, 1'b0, 11'h005, 8'h00);
        set_all(1, 1'b0, 11'h006, 8'h00);
        run(10, '0, 0, 0);

        run(200, 4'hF, 40, 30);
        run(40, 4'hF, 100, 100);
        run(10, '0, 0, 0);
        run(12, 4'h8, 100, 100);
        run(10, '0, 0, 0);
        set_all(1, 1'b0, 11'h003, 8'h00);
        set_all(3, 1'b0, 11'h004, 8'h00);
        run(2, 4'hB, 0, 100);
        set_all(0, 1'b0, 11'h006, 8'h00);
        run(8, '0, 0, 0);

        run(60, 4'hF, 60, 50);
        #2 reset_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("i%0d rst gnt", g), 64'(gnt[g]), 64'(0));
            check($sformatf("i%0d rst rvalid", g), 64'(rvalid[g]), 64'(0));
            check($sformatf("i%0d rst data_out", g), 64'(data_out[g]), 64'(0));
            check($sformatf("i%0d rst mem_en", g), 64'(mem_en[g]), 64'(0));
            check($sformatf("i%0d rst mem_we", g), 64'(mem_we[g]), 64'(0));
            check($sformatf("i%0d rst mem_addr", g), 64'(mem_addr[g]), 64'(0));
            check($sformatf("i%0d rst mem_wdata", g), 64'(mem_wdata[g]), 64'(0));
            req[g] = '0;
        end
        reset_model();
        run(2, '0, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run(200, 4'hF, 60, 50);
        run(8, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
